// File: rtl/pipelined_adder_tree_if.sv
// Handshake bundle for pipelined_adder_tree: input beat channel plus result channel.
// The master drives operands and out_ready; the slave (the adder tree) drives the results.
interface pipelined_adder_tree_if #(
    parameter int NUM_IN    = 3,
    parameter int IN_W      = 29,
    parameter int ACC_GUARD = 4
);
    localparam int LEVELS = $clog2(NUM_IN);
    localparam int SUM_W  = IN_W + LEVELS + ACC_GUARD;

    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_IN*IN_W-1:0]   in_data;
    logic                     acc_en;
    logic                     acc_clr;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [SUM_W-1:0]  sum;
    logic                     ovf;

    modport master (
        output in_valid, in_data, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, sum, ovf
    );

    modport slave (
        input  in_valid, in_data, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, sum, ovf
    );
endinterface

// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree with one registered stage per tree level, followed by a
// saturating accumulator/output register. Backpressure stalls the whole pipeline at once.
module pipelined_adder_tree #(
    parameter int NUM_IN    = 3,
    parameter int IN_W      = 29,
    parameter int ACC_GUARD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_adder_tree_if.slave bus
);
    localparam int LEVELS = $clog2(NUM_IN);
    localparam int SUM_W  = IN_W + LEVELS + ACC_GUARD;

    localparam logic signed [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

    function automatic int termCount(input int lvl);
        return (NUM_IN + (1 << lvl) - 1) >> lvl;
    endfunction

    logic signed [SUM_W-1:0] w_lvl   [LEVELS+1][NUM_IN];
    logic signed [SUM_W-1:0] r_stage [LEVELS][NUM_IN];
    logic [LEVELS-1:0]       r_vld;
    logic [LEVELS-1:0]       r_en;
    logic [LEVELS-1:0]       r_clr;

    logic                    w_adv;
    logic signed [SUM_W-1:0] w_tree;
    logic signed [SUM_W:0]   w_accWide;
    logic                    w_accOvf;
    logic signed [SUM_W-1:0] w_satVal;

    logic signed [SUM_W-1:0] r_sum;
    logic                    r_ovf;
    logic                    r_outValid;

    assign w_adv        = !r_outValid || bus.out_ready;
    assign bus.in_ready = w_adv;

    genvar gl, gk;
    generate
        for (gk = 0; gk < NUM_IN; gk++) begin : g_ext
            assign w_lvl[0][gk] = {{(SUM_W-IN_W){bus.in_data[gk*IN_W+IN_W-1]}},
                                   bus.in_data[gk*IN_W +: IN_W]};
        end

        for (gl = 1; gl <= LEVELS; gl++) begin : g_view
            for (gk = 0; gk < NUM_IN; gk++) begin : g_term
                assign w_lvl[gl][gk] = r_stage[gl-1][gk];
            end
        end

        // Each level pairs adjacent terms; an odd last term is registered unchanged.
        for (gl = 0; gl < LEVELS; gl++) begin : g_level
            for (gk = 0; gk < NUM_IN; gk++) begin : g_node
                if (2*gk+1 < termCount(gl)) begin : g_pair
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n)
                            r_stage[gl][gk] <= '0;
                        else if (w_adv)
                            r_stage[gl][gk] <= w_lvl[gl][2*gk] + w_lvl[gl][2*gk+1];
                    end
                end else if (2*gk < termCount(gl)) begin : g_pass
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n)
                            r_stage[gl][gk] <= '0;
                        else if (w_adv)
                            r_stage[gl][gk] <= w_lvl[gl][2*gk];
                    end
                end else begin : g_idle
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n)
                            r_stage[gl][gk] <= '0;
                        else
                            r_stage[gl][gk] <= '0;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_en  <= '0;
            r_clr <= '0;
        end else if (w_adv) begin
            r_vld[0] <= bus.in_valid;
            r_en[0]  <= bus.acc_en;
            r_clr[0] <= bus.acc_clr;
            for (int i = 1; i < LEVELS; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_en[i]  <= r_en[i-1];
                r_clr[i] <= r_clr[i-1];
            end
        end
    end

    // One extra bit of width exposes signed overflow of the accumulation.
    assign w_tree    = w_lvl[LEVELS][0];
    assign w_accWide = {r_sum[SUM_W-1], r_sum} + {w_tree[SUM_W-1], w_tree};
    assign w_accOvf  = w_accWide[SUM_W] != w_accWide[SUM_W-1];
    assign w_satVal  = w_accWide[SUM_W] ? SUM_MIN : SUM_MAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_sum      <= '0;
            r_ovf      <= 1'b0;
        end else if (w_adv) begin
            r_outValid <= r_vld[LEVELS-1];
            if (r_vld[LEVELS-1]) begin
                if (r_clr[LEVELS-1] || !r_en[LEVELS-1]) begin
                    r_sum <= w_tree;
                    r_ovf <= 1'b0;
                end else if (w_accOvf) begin
                    r_sum <= w_satVal;
                    r_ovf <= 1'b1;
                end else begin
                    r_sum <= w_accWide[SUM_W-1:0];
                end
            end
        end
    end

    assign bus.out_valid = r_outValid;
    assign bus.sum       = r_sum;
    assign bus.ovf       = r_ovf;
endmodule

// File: doc/pipelined_adder_tree.md
PIPELINED_ADDER_TREE -- requirements
Module: pipelined_adder_tree

Interface
REQ-001 Parameter NUM_IN, default 3: number of signed operands per beat; legal range 2..16.
REQ-002 Parameter IN_W, default 29: width of each signed operand.
REQ-003 Parameter ACC_GUARD, default 4: extra accumulator headroom bits.
REQ-004 Localparam LEVELS = clog2(NUM_IN); SUM_W = IN_W + LEVELS + ACC_GUARD.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  input beat valid.
REQ-008 in_ready  out  1  block accepts a beat this cycle.
REQ-009 in_data  in  NUM_IN*IN_W  packed operands, operand k at bits [k*IN_W +: IN_W], two's complement.
REQ-010 acc_en  in  1  sideband: add this beat's sum to the running accumulator.
REQ-011 acc_clr  in  1  sideband: restart the accumulator with this beat's sum.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 sum  out  SUM_W  signed result.
REQ-015 ovf  out  1  accumulator saturated since last restart.

Function
REQ-016 Operands shall be sign-extended to SUM_W before any addition; no intermediate wrap is permitted.
REQ-017 The tree shall have LEVELS registered stages; each stage pairs adjacent terms; an odd leftover term passes through registered unchanged.
REQ-018 An output/accumulator register shall follow the tree; latency from accepted beat to out_valid = LEVELS+1 cycles with no stall.
REQ-019 Each stage shall carry a valid bit plus acc_en/acc_clr sideband aligned with its data.
REQ-020 Pipeline advance enable adv = !out_valid | out_ready; in_ready shall equal adv.
REQ-021 A beat is accepted when in_valid & in_ready; when adv=0 all stages, valids and the output register shall hold.
REQ-022 Bubbles (in_valid=0 while adv=1) shall propagate as invalid stages; full throughput is one beat per cycle.
REQ-023 At the output stage, for a valid beat: acc_clr=1 -> sum = tree sum, ovf cleared; else acc_en=1 -> sum = sat(sum_prev + tree sum); else sum = tree sum, ovf cleared.
REQ-024 acc_clr shall take priority over acc_en when both are set.
REQ-025 Accumulation shall saturate to +(2^(SUM_W-1)-1) or -2^(SUM_W-1); on saturation ovf shall set and stay set until cleared per REQ-023.
REQ-026 sum_prev is the last valid output value, independent of whether it was consumed; invalid stages shall not modify sum or ovf.
REQ-027 out_valid shall remain high with sum stable until out_ready is sampled high (no result dropped or duplicated); results leave in acceptance order.

Reset
REQ-028 rst_n low shall immediately clear all stage valids, out_valid, sum and ovf to 0; in_ready shall be 1 while rst_n is high and out_valid=0.
REQ-029 Reset mid-operation shall discard all in-flight beats and the accumulator; the first beat after release behaves as after power-up (acc_en alone accumulates onto 0).

Verification (NUM_IN=3, IN_W=4, ACC_GUARD=4: LEVELS=2, SUM_W=10, range -512..511)
REQ-030 Reset asserted mid-stream -> out_valid=0, sum=0, ovf=0, in_ready=1 next cycle; no stale result appears after release.
REQ-031 One beat {7,7,7}, acc_en=0, out_ready=1 -> out_valid high exactly 3 cycles after acceptance, sum=21, ovf=0.
REQ-032 One beat {-8,-8,-8} -> sum=-24; beat {-8,7,1} -> sum=0.
REQ-033 Beat {7,7,7} with acc_clr=1, then 9 beats with acc_en=1 -> final sum=210; continue 15 more acc_en beats -> sum=511, ovf=1; next acc_clr beat {1,0,0} -> sum=1, ovf=0.
REQ-034 Back-to-back beats {1,0,0},{2,0,0},{3,0,0},{4,0,0} with out_ready low 5 cycles from first out_valid -> in_ready low while stalled, outputs 1,2,3,4 in order, none lost or repeated.
REQ-035 Alternating in_valid 1/0 with acc_en=1 beats {1,1,1} after acc_clr beat {0,0,0} -> bubbles do not alter sum; outputs 3,6,9,... on consecutive valid results.
